// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared constants and result flag type for pipelined_addsub
package pipelined_addsub_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
    } addsub_flags_t;

    // Signed overflow is the disagreement between the carries into and out of the MSB.
    function automatic addsub_flags_t make_flags(input logic carry_out, input logic carry_msb,
                                                 input logic is_zero, input logic sign);
        addsub_flags_t f;
        f.cout     = carry_out;
        f.overflow = carry_msb ^ carry_out;
        f.zero     = is_zero;
        f.negative = sign;
        return f;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - W-bit combinational slice adder with carry-in, carry-out and carry-into-MSB
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // The sum bit is a^b^carry_in, so the carry into the top bit falls out of it directly.
    assign cmsb = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep valid/ready pipelined adder/subtractor, one slice per stage
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int W = WIDTH / STAGES;

    // Stage k consumes the low slice of the operands still in flight and appends its
    // sum slice on top of the ones already completed, so widths shrink/grow by W per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * W;

        logic [REM-1:0]       a_cur;
        logic [REM-1:0]       b_cur;
        logic                 c_cur;
        logic                 load;
        logic                 adv;
        logic                 v_q;
        logic [W-1:0]         s_slice;
        logic                 c_out;
        logic [(k+1)*W-1:0]   s_next;

        if (k == 0) begin : g_head
            assign a_cur  = a;
            assign b_cur  = sub ? ~b : b;
            assign c_cur  = sub;
            assign load   = in_valid && in_ready;
            assign s_next = s_slice;
        end else begin : g_body
            assign a_cur  = g_stage[k-1].g_mid.a_q;
            assign b_cur  = g_stage[k-1].g_mid.b_q;
            assign c_cur  = g_stage[k-1].g_mid.c_q;
            assign load   = g_stage[k-1].adv;
            assign s_next = {s_slice, g_stage[k-1].g_mid.s_q};
        end

        if (k == STAGES - 1) begin : g_last
            logic          c_msb;
            logic [WIDTH-1:0] s_q;
            addsub_flags_t flags_q;

            addsub_slice #(.W(W)) u_slice (
                .a    (a_cur[W-1:0]),
                .b    (b_cur[W-1:0]),
                .cin  (c_cur),
                .s    (s_slice),
                .cout (c_out),
                .cmsb (c_msb)
            );

            assign adv = v_q && out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s_q     <= '0;
                    flags_q <= '0;
                end else if (load) begin
                    s_q     <= s_next;
                    flags_q <= make_flags(c_out, c_msb, s_next == '0, s_next[WIDTH-1]);
                end
            end
        end else begin : g_mid
            logic [REM-W-1:0]   a_q;
            logic [REM-W-1:0]   b_q;
            logic               c_q;
            logic [(k+1)*W-1:0] s_q;
            logic               cmsb_unused;

            addsub_slice #(.W(W)) u_slice (
                .a    (a_cur[W-1:0]),
                .b    (b_cur[W-1:0]),
                .cin  (c_cur),
                .s    (s_slice),
                .cout (c_out),
                .cmsb (cmsb_unused)
            );

            assign adv = v_q && (!g_stage[k+1].v_q || g_stage[k+1].adv);

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (load) begin
                    a_q <= a_cur[REM-1:W];
                    b_q <= b_cur[REM-1:W];
                    c_q <= c_out;
                    s_q <= s_next;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
            end else if (load) begin
                v_q <= 1'b1;
            end else if (adv) begin
                v_q <= 1'b0;
            end
        end
    end

    assign in_ready  = !g_stage[0].v_q || g_stage[0].adv;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].g_last.s_q;
    assign cout      = g_stage[STAGES-1].g_last.flags_q.cout;
    assign overflow  = g_stage[STAGES-1].g_last.flags_q.overflow;
    assign zero      = g_stage[STAGES-1].g_last.flags_q.zero;
    assign negative  = g_stage[STAGES-1].g_last.flags_q.negative;

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth; WIDTH mod STAGES SHALL be 0 and STAGES SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port sub, input, 1 bit: 1 selects a-b, 0 selects a+b.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for sub, 1 means no borrow.
REQ-013 The block SHALL have ports overflow, zero and negative, output, 1 bit each: signed overflow, sum==0, and sum[WIDTH-1].

Function
REQ-014 Add mode SHALL compute a + b + 0; sub mode SHALL compute a + ~b + 1, using the same carry chain.
REQ-015 Operands SHALL be split into STAGES slices of W=WIDTH/STAGES bits; stage k adds slice k (LSB first) with the carry registered from stage k-1.
REQ-016 Unprocessed operand slices and completed sum slices SHALL travel in delay registers alongside each stage.
REQ-017 A transfer SHALL occur on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-019 Each stage SHALL hold a valid bit; stage k advances when stage k+1 is empty or stage k+1 advances in the same cycle; the last stage advances on an output transfer.
REQ-020 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances), with a combinational path from out_ready permitted.
REQ-021 While out_valid=1 and out_ready=0, sum and all flags SHALL hold stable and no held data SHALL be lost or duplicated.
REQ-022 The pipeline SHALL hold STAGES results when full; with out_ready=0 and all stages valid, in_ready SHALL be 0.
REQ-023 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB; zero and negative SHALL come from the final WIDTH-bit sum.
REQ-024 Carries out of bit WIDTH-1 SHALL appear only on cout; the sum SHALL wrap modulo 2^WIDTH.
REQ-025 Simultaneous input and output transfers in a full pipeline SHALL both complete in the same cycle.
REQ-026 Operand values SHALL be ignored when in_valid=0, and no stage valid bit SHALL be set as a result.

Reset
REQ-027 When reset=1 at a clock edge, all stage valid bits SHALL clear, giving out_valid=0 on the next cycle.
REQ-028 After reset, in_ready SHALL be 1 while reset is low.
REQ-029 A reset mid-operation SHALL discard all in-flight results; none SHALL appear after reset.
REQ-030 After reset, sum, cout, overflow, zero and negative SHALL be 0; datapath registers SHALL be cleared.

Structure
REQ-031 A shared package SHALL hold the default WIDTH and STAGES constants and a packed struct for result flags (cout, overflow, zero, negative).
REQ-032 The per-stage slice adder SHALL be a sub-module, addsub_slice: a W-bit combinational ripple adder with cin/cout and a carry-into-MSB output.
REQ-033 The top level SHALL instantiate STAGES addsub_slice blocks in a generate loop.

Verification
REQ-034 With WIDTH=32, STAGES=4, idle out_ready=1, a=0x0000_0005, b=0x0000_0003, sub=0: the bench SHALL see out_valid after 4 cycles with sum=0x0000_0008 and cout=overflow=zero=negative=0.
REQ-035 With a=0x7FFF_FFFF, b=1, sub=0: the bench SHALL see sum=0x8000_0000, overflow=1, negative=1, cout=0.
REQ-036 With a=5, b=5, sub=1: the bench SHALL see sum=0, zero=1, cout=1; with a=0, b=1, sub=1: sum=0xFFFF_FFFF, cout=0, negative=1.
REQ-037 Streaming 10 back-to-back operations while holding out_ready=0 for 6 cycles SHALL give in_ready=0 after 4 accepts, with all 10 results delivered in order and none lost or duplicated.
REQ-038 Asserting reset with 3 results in flight SHALL give out_valid=0 the next cycle and no stale result afterwards.
REQ-039 Random a, b, sub with random in_valid/out_ready at WIDTH=8/STAGES=2 and WIDTH=64/STAGES=8 SHALL match a reference model on every output transfer.
